// File: rtl/scope_pkg.sv
// Shared types for the scope capture path: capture states, slope encoding, sample type.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } cap_state_t;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    typedef logic [7:0] sample_t;

endpackage

// File: rtl/trig_detect.sv
// Edge trigger comparator: keeps the previous written sample and flags a level crossing.
module trig_detect
    import scope_pkg::*;
(
    input  logic    sys_clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    upd,
    input  sample_t cur,
    input  sample_t level,
    input  logic    slope,
    output logic    hit
);

    sample_t prev;
    logic    have_prev;

    always_ff @(posedge sys_clk) begin
        if (rst || clr) begin
            prev      <= '0;
            have_prev <= 1'b0;
        end else if (upd) begin
            prev      <= cur;
            have_prev <= 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        unique case (slope)
            SLOPE_RISE: hit = have_prev && (prev < level) && (cur >= level);
            SLOPE_FALL: hit = have_prev && (prev > level) && (cur <= level);
        endcase
    end

endmodule

// File: rtl/capture_ctrl.sv
// Single-shot acquisition sequencer writing ADC samples into a ring RAM.
// Define AUTO_TRIG_EN to build the forced-trigger timeout counter.
module capture_ctrl
    import scope_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int PRE_TRIG     = 512,
    parameter int AUTO_TIMEOUT = 65536
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [7:0]        sample_data,
    input  logic              arm,
    input  logic              abort,
    input  logic [7:0]        trig_level,
    input  logic              trig_slope,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] frame_start,
    output logic              auto_trig
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFF  = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_LEN = ADDR_W'(DEPTH - PRE_TRIG - 1);

    cap_state_t        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic              hit;
    logic              timeout;
    logic              writing;
    logic              arm_start;
    logic              enter_armed;
    logic              trig_now;

    // POST with nothing left holds off writes for the single cycle before DONE
    assign writing = sample_valid && !abort &&
                     ((state == ST_PRETRIG) || (state == ST_ARMED) ||
                      ((state == ST_POST) && (post_cnt != '0)));
    assign arm_start   = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign enter_armed = (state == ST_PRETRIG) && writing && (pre_cnt == PRE_LAST);
    assign trig_now    = (state == ST_ARMED) && writing && (hit || timeout);

    trig_detect u_trig (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clr     (arm_start),
        .upd     (writing),
        .cur     (sample_data),
        .level   (trig_level),
        .slope   (trig_slope),
        .hit     (hit)
    );

`ifdef AUTO_TRIG_EN
    logic [31:0] auto_cnt;

    assign timeout = (auto_cnt == 32'(AUTO_TIMEOUT - 1));

    always_ff @(posedge sys_clk) begin
        if (rst || enter_armed) begin
            auto_cnt <= '0;
        end else if ((state == ST_ARMED) && writing) begin
            auto_cnt <= auto_cnt + 32'd1;
        end
    end
`else
    logic unused_auto_timeout;

    assign timeout             = 1'b0;
    assign unused_auto_timeout = (AUTO_TIMEOUT < 0);
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
            trig_addr    <= '0;
            frame_start  <= '0;
            auto_trig    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (writing) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= sample_data;
                ptr     <= ptr + ADDR_W'(1);
            end
            if (abort) begin
                state        <= ST_IDLE;
                busy         <= 1'b0;
                capture_done <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            state        <= ST_PRETRIG;
                            busy         <= 1'b1;
                            capture_done <= 1'b0;
                            ptr          <= '0;
                            pre_cnt      <= '0;
                            post_cnt     <= '0;
                            auto_trig    <= 1'b0;
                        end
                    end
                    ST_PRETRIG: begin
                        if (writing) begin
                            pre_cnt <= pre_cnt + ADDR_W'(1);
                            if (pre_cnt == PRE_LAST) state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_now) begin
                            trig_addr   <= ptr;
                            frame_start <= ptr - PRE_OFF;
                            auto_trig   <= ~hit;
                            post_cnt    <= POST_LEN;
                            state       <= ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (post_cnt == '0) begin
                            state        <= ST_DONE;
                            busy         <= 1'b0;
                            capture_done <= 1'b1;
                        end else if (writing) begin
                            post_cnt <= post_cnt - ADDR_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a 16-entry ring and 4 pre-trigger samples.
module tb_capture_ctrl;
    import scope_pkg::*;

    localparam int AW = 4;
    localparam int PT = 4;
    localparam int AT = 8;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_valid = 1'b0;
    logic [7:0]    sample_data = 8'h00;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    trig_level = 8'h00;
    logic          trig_slope = SLOPE_RISE;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          capture_done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] frame_start;
    logic          auto_trig;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          vld;
        logic [7:0]    data;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    vec_t ramp [17];

    capture_ctrl #(.ADDR_W(AW), .PRE_TRIG(PT), .AUTO_TIMEOUT(AT)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .arm          (arm),
        .abort        (abort),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .capture_done (capture_done),
        .trig_addr    (trig_addr),
        .frame_start  (frame_start),
        .auto_trig    (auto_trig)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic check_wr(input string name, input logic [AW-1:0] a, input logic [7:0] d);
        check({name, ".wr_en"}, 32'(wr_en), 32'd1);
        check({name, ".wr_addr"}, 32'(wr_addr), 32'(a));
        check({name, ".wr_data"}, 32'(wr_data), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            ramp[i] = '{1'b1, 8'(i * 16), 1'b1, AW'(i), 1'b1, 1'b0};
        ramp[16] = '{1'b0, 8'h00, 1'b0, '0, 1'b0, 1'b1};

        // reset state
        repeat (3) tick();
        check("rst.wr_en", 32'(wr_en), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(capture_done), 32'd0);
        check("rst.trig_addr", 32'(trig_addr), 32'd0);
        check("rst.frame_start", 32'(frame_start), 32'd0);
        check("rst.auto_trig", 32'(auto_trig), 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            send(8'h55);
            check("idle.wr_en", 32'(wr_en), 32'd0);
            check("idle.busy", 32'(busy), 32'd0);
        end

        // rising ramp, table driven
        trig_level = 8'h40;
        trig_slope = SLOPE_RISE;
        pulse_arm();
        check("rise.arm_busy", 32'(busy), 32'd1);
        check("rise.arm_wr", 32'(wr_en), 32'd0);
        for (int i = 0; i < 17; i++) begin
            if (ramp[i].vld) send(ramp[i].data);
            else tick();
            check($sformatf("rise[%0d].wr_en", i), 32'(wr_en), 32'(ramp[i].exp_wr));
            if (ramp[i].exp_wr) begin
                check($sformatf("rise[%0d].wr_addr", i), 32'(wr_addr), 32'(ramp[i].exp_addr));
                check($sformatf("rise[%0d].wr_data", i), 32'(wr_data), 32'(ramp[i].data));
            end
            check($sformatf("rise[%0d].busy", i), 32'(busy), 32'(ramp[i].exp_busy));
            check($sformatf("rise[%0d].done", i), 32'(capture_done), 32'(ramp[i].exp_done));
        end
        check("rise.trig_addr", 32'(trig_addr), 32'd4);
        check("rise.frame_start", 32'(frame_start), 32'd0);
        check("rise.auto_trig", 32'(auto_trig), 32'd0);
        send(8'h99);
        check("done.no_write", 32'(wr_en), 32'd0);
        check("done.hold", 32'(capture_done), 32'd1);
        check("done.hold_trig", 32'(trig_addr), 32'd4);

        // falling edge with pointer wrap
        trig_level = 8'h80;
        trig_slope = SLOPE_FALL;
        pulse_arm();
        check("fall.done_cleared", 32'(capture_done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            send(8'hF0);
            check_wr($sformatf("fall.pre%0d", i), AW'(i), 8'hF0);
        end
        send(8'h70);
        check_wr("fall.trig", AW'(10), 8'h70);
        check("fall.trig_addr", 32'(trig_addr), 32'd10);
        check("fall.frame_start", 32'(frame_start), 32'd6);
        for (int i = 0; i < 11; i++) begin
            send(8'h70);
            check_wr($sformatf("fall.post%0d", i), AW'(11 + i), 8'h70);
            check($sformatf("fall.post%0d.done", i), 32'(capture_done), 32'd0);
        end
        check("fall.last_addr", 32'(wr_addr), 32'd5);
        tick();
        check("fall.done", 32'(capture_done), 32'd1);
        check("fall.busy", 32'(busy), 32'd0);
        check("fall.wr_idle", 32'(wr_en), 32'd0);

        // abort during POST after 3 post writes
        trig_level = 8'h40;
        trig_slope = SLOPE_RISE;
        pulse_arm();
        for (int i = 0; i < 8; i++) send(8'(i * 16));
        check_wr("abort.third_post", AW'(7), 8'h70);
        sample_valid = 1'b1;
        sample_data  = 8'hAA;
        pulse_abort();
        sample_valid = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.wr_en", 32'(wr_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(8'hAA);
            check("abort.no_write", 32'(wr_en), 32'd0);
            check("abort.done", 32'(capture_done), 32'd0);
        end

        // arm with abort in the same cycle: abort wins
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("armabort.busy", 32'(busy), 32'd0);
        send(8'h11);
        check("armabort.no_write", 32'(wr_en), 32'd0);

        // arm while busy is ignored
        pulse_arm();
        send(8'h01);
        send(8'h02);
        check_wr("rearm.before", AW'(1), 8'h02);
        pulse_arm();
        check("rearm.busy", 32'(busy), 32'd1);
        send(8'h03);
        check_wr("rearm.after", AW'(2), 8'h03);
        pulse_abort();

        // constant input: only the timeout can trigger
        pulse_arm();
`ifdef AUTO_TRIG_EN
        for (int i = 0; i < 12; i++) send(8'h10);
        check_wr("auto.trig", AW'(11), 8'h10);
        check("auto.trig_addr", 32'(trig_addr), 32'd11);
        check("auto.frame_start", 32'(frame_start), 32'd7);
        check("auto.auto_trig", 32'(auto_trig), 32'd1);
        for (int i = 0; i < 11; i++) send(8'h10);
        check("auto.last_addr", 32'(wr_addr), 32'd6);
        tick();
        check("auto.done", 32'(capture_done), 32'd1);
`else
        for (int i = 0; i < 20; i++) send(8'h10);
        check_wr("noauto.wrap", AW'(3), 8'h10);
        check("noauto.busy", 32'(busy), 32'd1);
        check("noauto.done", 32'(capture_done), 32'd0);
        check("noauto.auto_trig", 32'(auto_trig), 32'd0);
        tick();
        check("noauto.still_busy", 32'(busy), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences one oscilloscope acquisition from the ADC front end: the 8-bit sample stream plus a one-cycle sample strobe (ADC clock falling-edge flag).
- Runs pre-trigger fill, armed ring-buffering, trigger detection and post-trigger fill, writing every sample into an external single-port sample RAM.
- Reports the trigger position and frame-complete status to the display/readout side.
- Sits between the ADC interface block and the waveform buffer RAM.

Parameters:
- ADDR_W, 10: sample RAM address width; DEPTH = 2**ADDR_W.
- PRE_TRIG, 512: samples stored before the trigger point; legal range 1..DEPTH-1.
- AUTO_TIMEOUT, 65536: armed samples without a trigger before a forced trigger (only used with AUTO_TRIG_EN).

Ports:
- sys_clk, in, 1: system clock, 100 MHz.
- rst, in, 1: synchronous reset, active-high.
- sample_valid, in, 1: one-cycle strobe, new sample present.
- sample_data, in, 8: unsigned ADC sample.
- arm, in, 1: pulse; start a capture.
- abort, in, 1: pulse; cancel the capture.
- trig_level, in, 8: unsigned trigger threshold; used live.
- trig_slope, in, 1: 0 = rising, 1 = falling.
- wr_en, out, 1: RAM write strobe.
- wr_addr, out, ADDR_W: RAM write address.
- wr_data, out, 8: RAM write data.
- busy, out, 1: high in PRETRIG, ARMED or POST.
- capture_done, out, 1: high while in DONE.
- trig_addr, out, ADDR_W: RAM address of the trigger sample.
- frame_start, out, ADDR_W: (trig_addr - PRE_TRIG) mod DEPTH, i.e. oldest sample of the frame.
- auto_trig, out, 1: last trigger was forced.

Behaviour:
- Interface is fixed: one clock sys_clk; reset rst is synchronous and active-high.
- Reset: state IDLE; wr_en, wr_addr, wr_data, busy, capture_done, trig_addr, frame_start, auto_trig all 0; internal counters and previous-sample register cleared.
- States: IDLE, PRETRIG, ARMED, POST, DONE.
- IDLE or DONE with arm=1 goes to PRETRIG. This clears the write pointer, pre/post counters, have_prev, auto_trig and capture_done. arm is ignored in every other state.
- abort=1 in any state goes to IDLE next cycle, and no wr_en is issued from that cycle on. If arm and abort arrive together, abort wins.
- Write path: in PRETRIG, ARMED and POST, each sample_valid causes one registered write with latency 1 cycle. wr_en is high for exactly that cycle, with wr_data = sample and wr_addr = pointer. The pointer then increments mod DEPTH (wraps DEPTH-1 to 0).
- Back-to-back sample_valid on consecutive cycles must be supported.
- PRETRIG: count written samples. After the PRE_TRIG-th write, go to ARMED. No trigger evaluation happens in PRETRIG, but the previous-sample register is updated.
- Trigger, rising: prev < trig_level and cur >= trig_level.
- Trigger, falling: prev > trig_level and cur <= trig_level.
- The first sample after arm has no prev (have_prev=0) and never triggers.
- ARMED: writes continue, overwriting the ring. On a trigger sample, that sample is written, trig_addr and frame_start are registered, and the state goes to POST with DEPTH-PRE_TRIG-1 samples remaining.
- POST: write the remaining samples. When the remaining count is 0 on entry, or after the last write, go to DONE.
- capture_done rises the cycle after the final wr_en.
- DONE: no writes; outputs hold until arm or rst.

Optional Feature:
- Macro: AUTO_TRIG_EN.
- Defined: an ARMED sample counter runs. If it reaches AUTO_TIMEOUT without a trigger, that sample becomes a forced trigger, treated exactly like a real one, and auto_trig=1. The counter resets on entry to ARMED.
- Not defined: no counter is built, ARMED waits indefinitely, and auto_trig is tied to 0. The port exists in both builds.

Decomposition:
- Package scope_pkg holds: capture state enum, slope encoding constants (SLOPE_RISE=0, SLOPE_FALL=1), and the 8-bit sample type.
- One sub-module, trig_detect: holds the prev-sample register and have_prev, and outputs a combinational hit for the current strobe.

Test Plan (bench uses ADDR_W=4, PRE_TRIG=4, AUTO_TIMEOUT=8):
- Reset, then idle strobes with no arm: all outputs 0, no wr_en.
- Arm, rising slope, level 0x40, ramp 0,16,32,48,64,80…: writes at addr 0..15; trigger on value 64 gives trig_addr=4, frame_start=0, auto_trig=0; capture_done one cycle after the 16th write.
- Arm, falling slope, level 0x80, 10 samples at 0xF0 then 0x70: wr_addr wraps 15 to 0; trig_addr=10, frame_start=6; capture ends after post write at addr 5.
- Abort during POST after 3 post writes: busy=0 next cycle, no further wr_en, capture_done stays 0.
- arm and abort asserted in the same cycle from IDLE: stays IDLE; arm while busy: ignored, pointer unchanged.
- AUTO_TRIG_EN defined, constant 0x10 input: forced trigger on the 8th armed sample, trig_addr=11, auto_trig=1. Without the macro, same stimulus stays ARMED indefinitely.
